instruction_encoder_loader: RTL and testbench
=============================================

# instruction_encoder_loader

Sequential instruction encoder and program loader for the Simple RISC Machine. It accepts decoded instruction fields over a valid/ready stream and packs each into a 16-bit instruction word, with field placement that inverts the CPU's decode. It writes each word into the instruction RAM at consecutive addresses from a base, reads it back, and verifies it. It sits between the test/boot host and the RAM port, ahead of CPU start.

## Interface
- ADDR_W, 8, RAM address width; top address = 2^ADDR_W-1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; starts a load session (accepted in IDLE, DONE, ERROR)
- base_addr  in  ADDR_W  first RAM address, sampled with start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  3  instruction class
- in_op  in  2  sub-op
- in_rn  in  3  Rn, or cond for branch opcode 001
- in_rd  in  3  Rd
- in_rm  in  3  Rm
- in_shift  in  2  shift field
- in_imm  in  16  signed immediate value, range-checked before truncation
- in_last  in  1  final word of session
- mem_addr  out  ADDR_W  RAM address
- mem_write  out  1  RAM write strobe
- mem_dout  out  16  RAM write data
- mem_din  in  16  RAM read data, valid the cycle after mem_addr is presented
- busy  out  1  session in progress
- done  out  1  session completed cleanly (level)
- err  out  1  session aborted (level)
- err_code  out  3  001 illegal encoding, 010 immediate range, 011 readback mismatch, 100 address overflow, 000 none
- count  out  ADDR_W+1  words written and verified this session

## Operation
- Encodings ({opcode,op,...}). Unused fields are forced to 0 regardless of input.
  - MOV Rn,#i8: 110 10 Rn i8
  - MOV Rd,Rm,sh: 110 00 000 Rd sh Rm
  - ALU (op 00 ADD, 01 CMP, 10 AND, 11 MVN): 101 op Rn Rd sh Rm. CMP forces Rd=000; MVN forces Rn=000.
  - LDR: 011 00 Rn Rd i5
  - STR: 100 00 Rn Rd i5
  - HALT: 111 00 0…0
  - B<cond>: 001 00 cond i8, cond 000–100
  - BL: 010 11 Rn i8
  - BX: 010 00 000 Rd 00000
  - BLX: 010 10 Rn Rd 00000
- Any other {opcode,op} combination, or cond>100, is an illegal encoding.
- Range: i8 must satisfy -128≤in_imm≤127; i5 must satisfy -16≤in_imm≤15. The value is then truncated two's-complement. in_imm is ignored for encodings without an immediate.
- FSM states: IDLE, ACCEPT, WRITE, READ, CHECK, DONE, ERROR.
  - IDLE: on start, set addr←base_addr, count←0, go to ACCEPT.
  - ACCEPT: in_ready=1. On in_valid, register word and last. Illegal encoding → ERROR(001); out-of-range immediate → ERROR(010); otherwise → WRITE.
  - WRITE: mem_write=1, mem_addr=addr, mem_dout=word → READ.
  - READ: mem_write=0, mem_addr=addr → CHECK.
  - CHECK: mem_din≠word → ERROR(011). Otherwise count++, then: last → DONE; else addr==top → ERROR(100); else addr++ → ACCEPT.
  - DONE/ERROR: hold done or err and err_code until start, which begins a new session (err_code←000, count←0). No RAM writes occur in these states.
- Illegal or out-of-range bundles are consumed but never written.
- start while busy is ignored.
- busy=1 in ACCEPT, WRITE, READ, CHECK.

## Timing
- Reset: state IDLE; in_ready, mem_write, busy, done, err = 0; err_code=000; count=0; mem_addr=0; mem_dout=0.
- Reset has priority over everything. Reset mid-session aborts with no further writes; RAM contents already written are kept.
- Throughput: 4 cycles per word (handshake, write, read, check) when in_valid is held high.
- in_ready is registered (a function of state only) and never depends combinationally on in_valid.
- done/err assert the cycle after the deciding CHECK/ACCEPT edge.
- mem_write is exactly one cycle per accepted legal word.

## Structure
- Shared package: opcode/op localparams, state encoding, err_code constants, i8/i5 range limits.
- One sub-module, instr_pack: combinational fields→{word, illegal, range_err}. It is reusable by the bench as a reference model.
- The top level holds the FSM, address counter, word/last registers, and count.

## Test plan
- base 0x10, stream MOV R0,#7; ADD R2,R1,R0,LSL(sh=01); LDR R3,[R1,#-1]; HALT(last) → RAM[0x10..0x13]=D007,A148,617F,E000; done=1; count=4.
- MOV R1,#200 → nothing written, err=1, err_code=010; MOV with #-128 → 0xD180 (R1) accepted.
- opcode 111 op 01 → err_code=001, mem_write never asserts.
- RAM model corrupts bit 0 on readback → err_code=011 after first word, count=0.
- base 0xFE, three non-last words → two written, err_code=100, count=2.
- reset asserted during READ → all outputs at reset values next cycle; new start runs cleanly; in_valid gaps stretch throughput with no extra writes.

Source files
------------

// File: rtl/instruction_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder / program loader.
//   - opcode and sub-op field values of the Simple RISC Machine ISA
//   - loader FSM state encoding
//   - err_code values reported by the loader
//   - signed immediate range limits and a range-check helper
package instruction_encoder_loader_pkg;

    // Instruction classes (bits [15:13])
    localparam logic [2:0] OPC_BCOND = 3'b001;
    localparam logic [2:0] OPC_BRREG = 3'b010;  // BL / BX / BLX
    localparam logic [2:0] OPC_LDR   = 3'b011;
    localparam logic [2:0] OPC_STR   = 3'b100;
    localparam logic [2:0] OPC_ALU   = 3'b101;
    localparam logic [2:0] OPC_MOV   = 3'b110;
    localparam logic [2:0] OPC_HALT  = 3'b111;

    // Sub-ops (bits [12:11])
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_BX      = 2'b00;
    localparam logic [1:0] OP_BLX     = 2'b10;
    localparam logic [1:0] OP_BL      = 2'b11;
    localparam logic [1:0] OP_NONE    = 2'b00;

    // Highest legal branch condition code
    localparam logic [2:0] COND_MAX = 3'b100;

    // err_code values
    localparam logic [2:0] ERR_NONE     = 3'b000;
    localparam logic [2:0] ERR_ILLEGAL  = 3'b001;
    localparam logic [2:0] ERR_RANGE    = 3'b010;
    localparam logic [2:0] ERR_READBACK = 3'b011;
    localparam logic [2:0] ERR_OVERFLOW = 3'b100;

    // Signed immediate limits
    localparam int I8_MIN = -128;
    localparam int I8_MAX = 127;
    localparam int I5_MIN = -16;
    localparam int I5_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    // True when the 16-bit two's-complement value lies in [lo, hi].
    function automatic logic imm_in_range(input logic [15:0] v, input int lo, input int hi);
        int sv;
        sv = int'($signed(v));
        return (sv >= lo) && (sv <= hi);
    endfunction

endpackage

// File: rtl/instruction_encoder_loader_instr_pack.sv
// instr_pack: purely combinational field packer.
// Turns a decoded field bundle into a 16-bit Simple RISC Machine word.
// Fields an encoding does not use are forced to zero.
//   opcode_i, op_i          instruction class / sub-op
//   rn_i, rd_i, rm_i        register fields (rn_i doubles as cond for B<cond>)
//   shift_i                 shift field
//   imm_i                   signed immediate, range-checked then truncated
//   word_o                  packed instruction (0 when illegal)
//   illegal_o               {opcode,op} / cond combination has no encoding
//   range_err_o             legal encoding but immediate out of range
module instr_pack
    import instruction_encoder_loader_pkg::*;
(
    input  logic [2:0]  opcode_i,
    input  logic [1:0]  op_i,
    input  logic [2:0]  rn_i,
    input  logic [2:0]  rd_i,
    input  logic [2:0]  rm_i,
    input  logic [1:0]  shift_i,
    input  logic [15:0] imm_i,
    output logic [15:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    logic need_i8;
    logic need_i5;

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        need_i8   = 1'b0;
        need_i5   = 1'b0;

        case (opcode_i)
            OPC_MOV: begin
                if (op_i == OP_MOV_IMM) begin
                    word_o  = {opcode_i, op_i, rn_i, imm_i[7:0]};
                    need_i8 = 1'b1;
                end else if (op_i == OP_MOV_REG) begin
                    word_o = {opcode_i, op_i, 3'b000, rd_i, shift_i, rm_i};
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_ALU: begin
                case (op_i)
                    OP_CMP:  word_o = {opcode_i, op_i, rn_i, 3'b000, shift_i, rm_i};
                    OP_MVN:  word_o = {opcode_i, op_i, 3'b000, rd_i, shift_i, rm_i};
                    default: word_o = {opcode_i, op_i, rn_i, rd_i, shift_i, rm_i};
                endcase
            end
            OPC_LDR, OPC_STR: begin
                if (op_i == OP_NONE) begin
                    word_o  = {opcode_i, op_i, rn_i, rd_i, imm_i[4:0]};
                    need_i5 = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_HALT: begin
                if (op_i == OP_NONE) word_o = {opcode_i, op_i, 11'b0};
                else                 illegal_o = 1'b1;
            end
            OPC_BCOND: begin
                if (op_i == OP_NONE && rn_i <= COND_MAX) begin
                    word_o  = {opcode_i, op_i, rn_i, imm_i[7:0]};
                    need_i8 = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_BRREG: begin
                case (op_i)
                    OP_BL: begin
                        word_o  = {opcode_i, op_i, rn_i, imm_i[7:0]};
                        need_i8 = 1'b1;
                    end
                    OP_BX:   word_o = {opcode_i, op_i, 3'b000, rd_i, 5'b0};
                    OP_BLX:  word_o = {opcode_i, op_i, rn_i, rd_i, 5'b0};
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase

        if (illegal_o) word_o = '0;
    end

    // Range errors are reported only for encodings that carry an immediate;
    // an illegal bundle never reports a range error.
    assign range_err_o = !illegal_o &&
                         ((need_i8 && !imm_in_range(imm_i, I8_MIN, I8_MAX)) ||
                          (need_i5 && !imm_in_range(imm_i, I5_MIN, I5_MAX)));

endmodule

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: accepts decoded instruction bundles over a
// valid/ready stream, encodes each, writes it to instruction RAM at
// consecutive addresses from base_addr_i, reads it back and verifies it.
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, base_addr_i    begin a load session at base_addr_i
//   in_*                    field bundle stream (valid/ready, in_last_i ends session)
//   mem_addr_o/write/dout   RAM port; mem_din_i is read data one cycle after address
//   busy_o, done_o, err_o   session status; err_code_o gives abort reason
//   count_o                 words written and verified this session
module instruction_encoder_loader
    import instruction_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_opcode_i,
    input  logic [1:0]        in_op_i,
    input  logic [2:0]        in_rn_i,
    input  logic [2:0]        in_rd_i,
    input  logic [2:0]        in_rm_i,
    input  logic [1:0]        in_shift_i,
    input  logic [15:0]       in_imm_i,
    input  logic              in_last_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic [15:0]       mem_dout_o,
    input  logic [15:0]       mem_din_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        err_code_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [2:0]        err_code_q, err_code_d;

    logic [15:0] pk_word;
    logic        pk_illegal;
    logic        pk_range_err;

    instr_pack u_pack (
        .opcode_i   (in_opcode_i),
        .op_i       (in_op_i),
        .rn_i       (in_rn_i),
        .rd_i       (in_rd_i),
        .rm_i       (in_rm_i),
        .shift_i    (in_shift_i),
        .imm_i      (in_imm_i),
        .word_o     (pk_word),
        .illegal_o  (pk_illegal),
        .range_err_o(pk_range_err)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        last_d     = last_q;
        count_d    = count_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    addr_d     = base_addr_i;
                    count_d    = '0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid_i) begin
                    if (pk_illegal) begin
                        err_code_d = ERR_ILLEGAL;
                        state_d    = ST_ERROR;
                    end else if (pk_range_err) begin
                        err_code_d = ERR_RANGE;
                        state_d    = ST_ERROR;
                    end else begin
                        word_d  = pk_word;
                        last_d  = in_last_i;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: state_d = ST_READ;
            ST_READ:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (mem_din_i != word_q) begin
                    err_code_d = ERR_READBACK;
                    state_d    = ST_ERROR;
                end else begin
                    count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (addr_q == ADDR_TOP) begin
                        // The verified word sits at the top address; there is
                        // nowhere to put the next one.
                        err_code_d = ERR_OVERFLOW;
                        state_d    = ST_ERROR;
                    end else begin
                        addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All status outputs decode straight from registered state.
    assign in_ready_o  = (state_q == ST_ACCEPT);
    assign mem_write_o = (state_q == ST_WRITE);
    assign busy_o      = (state_q == ST_ACCEPT) || (state_q == ST_WRITE) ||
                         (state_q == ST_READ)   || (state_q == ST_CHECK);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERROR);
    assign mem_addr_o  = addr_q;
    assign mem_dout_o  = word_q;
    assign err_code_o  = err_code_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
module tb_instruction_encoder_loader;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  base_addr_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [2:0]  in_opcode_i = '0;
    logic [1:0]  in_op_i = '0;
    logic [2:0]  in_rn_i = '0, in_rd_i = '0, in_rm_i = '0;
    logic [1:0]  in_shift_i = '0;
    logic [15:0] in_imm_i = '0;
    logic        in_last_i = 1'b0;
    logic [7:0]  mem_addr_o;
    logic        mem_write_o;
    logic [15:0] mem_dout_o;
    logic [15:0] mem_din_i;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_code_o;
    logic [8:0]  count_o;

    instruction_encoder_loader #(.ADDR_W(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_opcode_i(in_opcode_i),
        .in_op_i(in_op_i), .in_rn_i(in_rn_i), .in_rd_i(in_rd_i), .in_rm_i(in_rm_i),
        .in_shift_i(in_shift_i), .in_imm_i(in_imm_i), .in_last_i(in_last_i),
        .mem_addr_o(mem_addr_o), .mem_write_o(mem_write_o), .mem_dout_o(mem_dout_o),
        .mem_din_i(mem_din_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: synchronous write, registered read; corrupt flips bit 0 on read.
    logic [15:0] ram [0:255];
    logic [15:0] rd_q = '0;
    logic        corrupt = 1'b0;
    int          cyc = 0;
    assign mem_din_i = rd_q;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (mem_write_o) ram[mem_addr_o] <= mem_dout_o;
        rd_q <= ram[mem_addr_o] ^ {15'b0, corrupt};
    end

    typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
    wr_t sb[$];
    wr_t mon_e;
    int  pass_cnt = 0, total_cnt = 0, writes = 0, t0 = 0;

    // Scoreboard monitor: every RAM write must match the next expected entry.
    always begin
        @(negedge clk_i);
        if (mem_write_o === 1'b1) begin
            writes++;
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write addr=%h data=%h required=no write", mem_addr_o, mem_dout_o);
            end else begin
                mon_e = sb.pop_front();
                if (mem_addr_o !== mon_e.addr || mem_dout_o !== mon_e.data)
                    $display("FAIL write_data got=%h:%h required=%h:%h", mem_addr_o, mem_dout_o, mon_e.addr, mon_e.data);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic start_sess(input logic [7:0] base);
        start_i = 1'b1; base_addr_i = base;
        tick();
        start_i = 1'b0;
        t0 = cyc;
    endtask

    task automatic send(input string nm, input logic [2:0] opc, input logic [1:0] op,
                        input logic [2:0] rn, input logic [2:0] rd, input logic [2:0] rm,
                        input logic [1:0] sh, input logic [15:0] imm, input logic last,
                        input bit exp_acc, input int budget);
        bit acc;
        acc = 1'b0;
        in_opcode_i = opc; in_op_i = op; in_rn_i = rn; in_rd_i = rd; in_rm_i = rm;
        in_shift_i = sh; in_imm_i = imm; in_last_i = last; in_valid_i = 1'b1;
        for (int i = 0; i < budget && !acc; i++) begin
            if (in_ready_o) acc = 1'b1;
            tick();
        end
        in_valid_i = 1'b0;
        total_cnt++;
        if (acc !== exp_acc) $display("FAIL accept_%s got=%0d required=%0d", nm, acc, exp_acc);
        else pass_cnt++;
    endtask

    task automatic wait_end(input string nm, output int lat);
        for (int i = 0; i < 200; i++) begin
            if (done_o || err_o) break;
            tick();
        end
        lat = cyc - t0;
        total_cnt++;
        if (!(done_o || err_o)) $display("FAIL end_%s timeout got=busy required=done or err", nm);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
        tick();
        total_cnt++;
        if ({in_ready_o, mem_write_o, busy_o, done_o, err_o} !== 5'b0)
            $display("FAIL reset_flags got=%b required=00000", {in_ready_o, mem_write_o, busy_o, done_o, err_o});
        else pass_cnt++;
        total_cnt++;
        if (err_code_o !== 3'b000) $display("FAIL reset_err_code got=%b required=000", err_code_o); else pass_cnt++;
        total_cnt++;
        if (count_o !== 9'd0) $display("FAIL reset_count got=%0d required=0", count_o); else pass_cnt++;
        total_cnt++;
        if (mem_addr_o !== 8'h00 || mem_dout_o !== 16'h0000)
            $display("FAIL reset_mem got=%h/%h required=00/0000", mem_addr_o, mem_dout_o);
        else pass_cnt++;
    endtask

    task automatic test_program();
        int lat;
        logic [15:0] exp_w [4];
        exp_w[0] = 16'hD007; exp_w[1] = 16'hA148; exp_w[2] = 16'h617F; exp_w[3] = 16'hE000;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), exp_w[i]);
        start_sess(8'h10);
        send("mov_imm", 3'b110, 2'b10, 3'd0, 3'd5, 3'd6, 2'b11, 16'd7, 1'b0, 1'b1, 20);
        send("add",     3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'b01, 16'hFFFF, 1'b0, 1'b1, 20);
        send("ldr",     3'b011, 2'b00, 3'd1, 3'd3, 3'd7, 2'b10, 16'hFFFF, 1'b0, 1'b1, 20);
        send("halt",    3'b111, 2'b00, 3'd7, 3'd7, 3'd7, 2'b11, 16'h1234, 1'b1, 1'b1, 20);
        wait_end("program", lat);
        total_cnt++;
        if (done_o !== 1'b1 || err_o !== 1'b0) $display("FAIL prog_done got=%b%b required=10", done_o, err_o); else pass_cnt++;
        total_cnt++;
        if (count_o !== 9'd4) $display("FAIL prog_count got=%0d required=4", count_o); else pass_cnt++;
        total_cnt++;
        if (lat !== 16) $display("FAIL prog_latency got=%0d required=16", lat); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (ram[8'h10 + 8'(i)] !== exp_w[i])
                $display("FAIL prog_ram%0d got=%h required=%h", i, ram[8'h10 + 8'(i)], exp_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_range();
        int lat, w0;
        w0 = writes;
        start_sess(8'h20);
        send("mov200", 3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 16'd200, 1'b1, 1'b1, 20);
        wait_end("range_i8", lat);
        total_cnt++;
        if (err_o !== 1'b1 || err_code_o !== 3'b010) $display("FAIL range_i8_code got=%b/%b required=1/010", err_o, err_code_o); else pass_cnt++;
        total_cnt++;
        if (writes !== w0 || count_o !== 9'd0) $display("FAIL range_i8_nowrite got=%0d/%0d required=0/0", writes - w0, count_o); else pass_cnt++;

        push(8'h20, 16'hD180);
        start_sess(8'h20);
        send("mov_m128", 3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 16'hFF80, 1'b1, 1'b1, 20);
        wait_end("range_m128", lat);
        total_cnt++;
        if (done_o !== 1'b1 || err_code_o !== 3'b000 || count_o !== 9'd1)
            $display("FAIL range_m128_done got=%b/%b/%0d required=1/000/1", done_o, err_code_o, count_o);
        else pass_cnt++;
        total_cnt++;
        if (ram[8'h20] !== 16'hD180) $display("FAIL range_m128_ram got=%h required=d180", ram[8'h20]); else pass_cnt++;

        w0 = writes;
        start_sess(8'h28);
        send("ldr16", 3'b011, 2'b00, 3'd1, 3'd2, 3'd0, 2'b00, 16'd16, 1'b1, 1'b1, 20);
        wait_end("range_i5", lat);
        total_cnt++;
        if (err_code_o !== 3'b010 || writes !== w0) $display("FAIL range_i5 got=%b/%0d required=010/0", err_code_o, writes - w0); else pass_cnt++;
    endtask

    task automatic test_illegal();
        int lat, w0;
        w0 = writes;
        start_sess(8'h30);
        send("op111_01", 3'b111, 2'b01, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0, 1'b1, 1'b1, 20);
        wait_end("illegal_halt", lat);
        total_cnt++;
        if (err_o !== 1'b1 || err_code_o !== 3'b001) $display("FAIL illegal_halt got=%b/%b required=1/001", err_o, err_code_o); else pass_cnt++;
        start_sess(8'h30);
        send("cond101", 3'b001, 2'b00, 3'b101, 3'd0, 3'd0, 2'b00, 16'd1, 1'b1, 1'b1, 20);
        wait_end("illegal_cond", lat);
        total_cnt++;
        if (err_code_o !== 3'b001) $display("FAIL illegal_cond got=%b required=001", err_code_o); else pass_cnt++;
        total_cnt++;
        if (writes !== w0) $display("FAIL illegal_nowrite got=%0d required=0", writes - w0); else pass_cnt++;
    endtask

    task automatic test_encodings();
        int lat;
        logic [15:0] exp_w [9];
        exp_w = '{16'hA902, 16'hB864, 16'h40A0, 16'h5EFF, 16'h2405, 16'h5140, 16'hC0F3, 16'hB279, 16'h8350};
        for (int i = 0; i < 9; i++) push(8'h40 + 8'(i), exp_w[i]);
        start_sess(8'h40);
        send("cmp",  3'b101, 2'b01, 3'd1, 3'd7, 3'd2, 2'b00, 16'hFFFF, 1'b0, 1'b1, 20);
        send("mvn",  3'b101, 2'b11, 3'd5, 3'd3, 3'd4, 2'b00, 16'hFFFF, 1'b0, 1'b1, 20);
        send("bx",   3'b010, 2'b00, 3'd7, 3'd5, 3'd7, 2'b11, 16'hFFFF, 1'b0, 1'b1, 20);
        send("bl",   3'b010, 2'b11, 3'd6, 3'd7, 3'd7, 2'b11, 16'hFFFF, 1'b0, 1'b1, 20);
        send("bc4",  3'b001, 2'b00, 3'd4, 3'd7, 3'd7, 2'b11, 16'd5,    1'b0, 1'b1, 20);
        send("blx",  3'b010, 2'b10, 3'd1, 3'd2, 3'd7, 2'b11, 16'hFFFF, 1'b0, 1'b1, 20);
        send("movr", 3'b110, 2'b00, 3'd5, 3'd7, 3'd3, 2'b10, 16'hFFFF, 1'b0, 1'b1, 20);
        send("and",  3'b101, 2'b10, 3'd2, 3'd3, 3'd1, 2'b11, 16'hFFFF, 1'b0, 1'b1, 20);
        send("str",  3'b100, 2'b00, 3'd3, 3'd2, 3'd7, 2'b11, 16'hFFF0, 1'b1, 1'b1, 20);
        wait_end("encodings", lat);
        total_cnt++;
        if (done_o !== 1'b1 || count_o !== 9'd9) $display("FAIL enc_done got=%b/%0d required=1/9", done_o, count_o); else pass_cnt++;
    endtask

    task automatic test_readback();
        int lat;
        corrupt = 1'b1;
        push(8'h38, 16'hD007);
        start_sess(8'h38);
        send("rb_mov", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'd7, 1'b0, 1'b1, 20);
        wait_end("readback", lat);
        corrupt = 1'b0;
        total_cnt++;
        if (err_o !== 1'b1 || err_code_o !== 3'b011 || count_o !== 9'd0)
            $display("FAIL readback got=%b/%b/%0d required=1/011/0", err_o, err_code_o, count_o);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat;
        push(8'hFE, 16'hD007);
        push(8'hFF, 16'hD001);
        start_sess(8'hFE);
        send("ov0", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'd7, 1'b0, 1'b1, 20);
        send("ov1", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'd1, 1'b0, 1'b1, 20);
        send("ov2", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'd2, 1'b0, 1'b0, 10);
        wait_end("overflow", lat);
        total_cnt++;
        if (err_code_o !== 3'b100 || count_o !== 9'd2) $display("FAIL overflow got=%b/%0d required=100/2", err_code_o, count_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, w0;
        push(8'h50, 16'hD007);
        start_sess(8'h50);
        send("rst_mov", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'd7, 1'b0, 1'b1, 20);
        tick();  // now in READ
        reset_i = 1'b1;
        tick();
        total_cnt++;
        if ({in_ready_o, mem_write_o, busy_o, done_o, err_o} !== 5'b0 || count_o !== 9'd0 ||
            err_code_o !== 3'b000 || mem_addr_o !== 8'h00 || mem_dout_o !== 16'h0000)
            $display("FAIL midreset got=%b/%0d/%b/%h/%h required=00000/0/000/00/0000",
                     {in_ready_o, mem_write_o, busy_o, done_o, err_o}, count_o, err_code_o, mem_addr_o, mem_dout_o);
        else pass_cnt++;
        tick();
        reset_i = 1'b0;
        tick();

        w0 = writes;
        push(8'h60, 16'hD105); push(8'h61, 16'hA148); push(8'h62, 16'hE000);
        start_sess(8'h60);
        send("g0", 3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 16'd5, 1'b0, 1'b1, 20);
        repeat (6) tick();
        send("g1", 3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'b01, 16'd0, 1'b0, 1'b1, 20);
        repeat (3) tick();
        send("g2", 3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0, 1'b1, 1'b1, 20);
        wait_end("gaps", lat);
        total_cnt++;
        if (done_o !== 1'b1 || count_o !== 9'd3) $display("FAIL gaps_done got=%b/%0d required=1/3", done_o, count_o); else pass_cnt++;
        total_cnt++;
        if (writes - w0 !== 3) $display("FAIL gaps_writes got=%0d required=3", writes - w0); else pass_cnt++;
        total_cnt++;
        if (lat <= 12) $display("FAIL gaps_latency got=%0d required=>12", lat); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        test_reset();
        test_program();
        test_range();
        test_illegal();
        test_encodings();
        test_readback();
        test_overflow();
        test_back_to_back();
        repeat (3) tick();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_left got=%0d required=0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
